// File: rtl/cmd_cobs_encode.sv
// cmd_cobs_encode: takes one (address, data) word, COBS-encodes the
// fixed-length payload (address bytes then data bytes, MSB byte first)
// and emits it as a single-block frame terminated by a 0x00 delimiter.
module cmd_cobs_encode #(
    parameter int AW = 8,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [7:0]    o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_last
);

    localparam int N  = (AW + DW) / 8;
    localparam int PW = $clog2(N + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CODE,
        S_DATA,
        S_DELIM
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N*8-1:0]  r_buf;
    logic [PW-1:0]   r_p;
    logic [PW-1:0]   w_p_nxt;
    logic [7:0]      r_data;
    logic [7:0]      w_data_nxt;
    logic            w_load;
    logic [7:0]      w_byte_p;
    logic [7:0]      w_byte_p1;

    // Payload byte idx (byte 0 sits in the most significant position)
    function automatic logic [7:0] f_byte(input logic [N*8-1:0] b, input logic [PW-1:0] idx);
        logic [7:0] v;
        v = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (idx == PW'(k)) v = b[(N-1-k)*8 +: 8];
        end
        return v;
    endfunction

    // COBS code for the run starting at idx: 1 + nonzero bytes before the
    // next zero or the payload end; idx==N naturally yields 0x01
    function automatic logic [7:0] f_code(input logic [N*8-1:0] b, input logic [PW-1:0] idx);
        logic [7:0] cnt;
        logic       stop;
        cnt  = 8'd1;
        stop = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (PW'(k) >= idx && !stop) begin
                if (b[(N-1-k)*8 +: 8] == 8'h00) stop = 1'b1;
                else                            cnt  = cnt + 8'd1;
            end
        end
        return cnt;
    endfunction

    // Next-state, next index and next output byte; o_data is registered so
    // each transition precomputes the byte shown in the destination state
    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_data_nxt  = r_data;
        w_load      = 1'b0;
        w_byte_p    = f_byte(r_buf, r_p);
        w_byte_p1   = f_byte(r_buf, r_p + PW'(1));
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_load      = 1'b1;
                    w_p_nxt     = '0;
                    w_state_nxt = S_CODE;
                    w_data_nxt  = f_code({i_addr, i_data}, '0);
                end
            end
            S_CODE: begin
                if (i_ready) begin
                    if (r_p == PW'(N)) begin
                        w_state_nxt = S_DELIM;
                        w_data_nxt  = 8'h00;
                    end else if (w_byte_p == 8'h00) begin
                        // empty run: skip the zero and emit the next code
                        w_p_nxt     = r_p + PW'(1);
                        w_state_nxt = S_CODE;
                        w_data_nxt  = f_code(r_buf, r_p + PW'(1));
                    end else begin
                        w_state_nxt = S_DATA;
                        w_data_nxt  = w_byte_p;
                    end
                end
            end
            S_DATA: begin
                if (i_ready) begin
                    if (r_p + PW'(1) == PW'(N)) begin
                        w_p_nxt     = r_p + PW'(1);
                        w_state_nxt = S_DELIM;
                        w_data_nxt  = 8'h00;
                    end else if (w_byte_p1 == 8'h00) begin
                        w_p_nxt     = r_p + PW'(2);
                        w_state_nxt = S_CODE;
                        w_data_nxt  = f_code(r_buf, r_p + PW'(2));
                    end else begin
                        w_p_nxt     = r_p + PW'(1);
                        w_state_nxt = S_DATA;
                        w_data_nxt  = w_byte_p1;
                    end
                end
            end
            S_DELIM: begin
                if (i_ready) begin
                    w_state_nxt = S_IDLE;
                    w_data_nxt  = 8'h00;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_data_nxt  = 8'h00;
            end
        endcase
    end

    // State, index, output byte and payload buffer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_data  <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_data  <= w_data_nxt;
            if (w_load) r_buf <= {i_addr, i_data};
        end
    end

    assign o_ready = (r_state == S_IDLE);
    assign o_valid = (r_state != S_IDLE);
    assign o_last  = (r_state == S_DELIM);
    assign o_data  = r_data;

endmodule

// File: tb/tb_cmd_cobs_encode.sv
// Directed and loopback bench for cmd_cobs_encode (AW=8, DW=24).
module tb_cmd_cobs_encode;

    logic        clk;
    logic        rst;
    logic [7:0]  i_addr;
    logic [23:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_last;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] cap      [0:31];
    logic       cap_last [0:31];
    int         cap_n;

    typedef struct {
        logic [7:0]  addr;
        logic [23:0] data;
        logic [47:0] exp;   // six frame bytes, first byte in the MSBs
    } vec_t;

    vec_t vecs [6];

    cmd_cobs_encode #(.AW(8), .DW(24)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_addr  (i_addr),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_last  (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [7:0] a, input logic [23:0] d);
        @(negedge clk);
        i_addr  = a;
        i_data  = d;
        i_valid = 1'b1;
        #1;
        chk("o_ready in idle", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_addr  = 8'($urandom);
        i_data  = 24'($urandom);
        chk("o_ready while busy", 64'(o_ready), 64'd0);
    endtask

    task automatic collect(input bit rnd);
        bit         stalled;
        bit         done;
        logic [7:0] pd;
        logic       pl;
        stalled = 1'b0;
        done    = 1'b0;
        pd      = '0;
        pl      = 1'b0;
        cap_n   = 0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (cyc == 0) chk("first code latency", 64'(o_valid), 64'd1);
            if (o_valid) begin
                if (stalled) begin
                    chk("stall data stable", 64'(o_data), 64'(pd));
                    chk("stall last stable", 64'(o_last), 64'(pl));
                end
                if (i_ready) begin
                    if (cap_n < 32) begin
                        cap[cap_n]      = o_data;
                        cap_last[cap_n] = o_last;
                    end
                    cap_n++;
                    stalled = 1'b0;
                    if (o_last) done = 1'b1;
                end else begin
                    stalled = 1'b1;
                    pd      = o_data;
                    pl      = o_last;
                end
            end
        end
        if (!done) chk("frame timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        i_ready = 1'b1;
        chk("o_ready after delim", 64'(o_ready), 64'd1);
        chk("o_valid after delim", 64'(o_valid), 64'd0);
    endtask

    task automatic check_frame(input string name, input logic [47:0] exp);
        chk({name, " length"}, 64'(cap_n), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk({name, " byte"}, 64'(cap[i]), 64'(exp[47-8*i -: 8]));
            chk({name, " last"}, 64'(cap_last[i]), 64'(i == 5));
        end
    endtask

    // Independent COBS decode of the captured frame back into a 32-bit word
    task automatic check_loopback(input logic [7:0] a, input logic [23:0] d);
        int         n;
        int         idx;
        int         nb;
        int         zeros;
        logic [7:0] code;
        logic [31:0] w;
        n     = (cap_n > 32) ? 32 : cap_n;
        idx   = 0;
        nb    = 0;
        zeros = 0;
        w     = '0;
        for (int i = 0; i < n - 1; i++) if (cap[i] == 8'h00) zeros++;
        while (idx < n - 1) begin
            code = cap[idx];
            idx++;
            if (code == 8'h00) break;
            for (int j = 1; j < int'(code); j++) begin
                if (idx < n - 1) begin
                    w = {w[23:0], cap[idx]};
                    nb++;
                    idx++;
                end
            end
            if (code != 8'hFF && idx < n - 1) begin
                w = {w[23:0], 8'h00};
                nb++;
            end
        end
        chk("loop length", 64'(cap_n), 64'd6);
        chk("loop no inner zero", 64'(zeros), 64'd0);
        chk("loop delimiter", 64'(cap[n-1]), 64'h00);
        chk("loop byte count", 64'(nb), 64'd4);
        chk("loop word", 64'(w), 64'({a, d}));
    endtask

    function automatic logic [7:0] zbyte();
        return ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    endfunction

    initial begin
        vecs[0] = '{8'h01, 24'h020304, 48'h05_01_02_03_04_00};
        vecs[1] = '{8'h00, 24'h000000, 48'h01_01_01_01_01_00};
        vecs[2] = '{8'h00, 24'h112200, 48'h01_03_11_22_01_00};
        vecs[3] = '{8'hAA, 24'hBB00CC, 48'h03_AA_BB_02_CC_00};
        vecs[4] = '{8'h12, 24'h0000FF, 48'h02_12_01_02_FF_00};
        vecs[5] = '{8'h00, 24'hABCDEF, 48'h01_04_AB_CD_EF_00};

        rst     = 1'b1;
        i_addr  = '0;
        i_data  = '0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        #3;
        chk("reset o_ready", 64'(o_ready), 64'd1);
        chk("reset o_valid", 64'(o_valid), 64'd0);
        chk("reset o_last", 64'(o_last), 64'd0);
        chk("reset o_data", 64'(o_data), 64'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            send_word(vecs[v].addr, vecs[v].data);
            collect(1'b0);
            check_frame("vec", vecs[v].exp);
        end

        for (int r = 0; r < 3; r++) begin
            send_word(8'hAA, 24'hBB00CC);
            collect(1'b1);
            check_frame("stalled", 48'h03_AA_BB_02_CC_00);
        end

        // Reset in the middle of a frame
        i_ready = 1'b1;
        send_word(8'h01, 24'h020304);
        @(negedge clk);
        #1;
        chk("abort byte0", 64'(o_data), 64'h05);
        @(negedge clk);
        #1;
        chk("abort byte1", 64'(o_data), 64'h01);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort o_valid", 64'(o_valid), 64'd0);
        chk("abort o_ready", 64'(o_ready), 64'd1);
        chk("abort o_last", 64'(o_last), 64'd0);
        chk("abort o_data", 64'(o_data), 64'h00);
        @(negedge clk);
        rst = 1'b0;
        send_word(vecs[2].addr, vecs[2].data);
        collect(1'b0);
        check_frame("after abort", vecs[2].exp);

        for (int t = 0; t < 200; t++) begin
            logic [7:0]  a;
            logic [23:0] d;
            a = zbyte();
            d = {zbyte(), zbyte(), zbyte()};
            send_word(a, d);
            collect(t[0]);
            check_loopback(a, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
